// File: rtl/arb_pkg.sv
// Shared constants and the wrap-around priority search
// for the arbitrating output multiplexer.
package arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int MAXCH = 32;
    localparam int MAXCW = 5;

    // First set bit at or after start, wrapping at n; -1 if none.
    function automatic int rr_pick(
        input logic [MAXCH-1:0] req,
        input int               start,
        input int               n
    );
        int pick;
        int idx;
        pick = -1;
        for (int k = 0; k < MAXCH; k++) begin
            if (k < n && pick < 0) begin
                idx = start + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[MAXCW-1:0]]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Fixed-priority or round-robin arbiter; owns the
// rotating pointer, which moves past each winner.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int MODE = ARB_RR,
    parameter int CW   = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           advance,
    output logic [NCH-1:0] grant,
    output logic [CW-1:0]  grant_idx,
    output logic           any
);

    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    logic [CW-1:0]    ptr;
    logic [MAXCH-1:0] req_w;
    int               start;
    int               pick;

    always_comb begin
        req_w          = '0;
        req_w[NCH-1:0] = req;
        start          = (MODE == ARB_RR) ? int'(ptr) : 0;
        pick           = rr_pick(req_w, start, NCH);
        any            = (pick >= 0);
        grant_idx      = any ? pick[CW-1:0] : '0;
        grant          = '0;
        if (any) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (MODE == ARB_RR && advance && any) begin
            ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrating mux into a single registered
// output slot with valid/ready handshake on both sides.
module arb_mux
    import arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int MODE  = ARB_RR,
    parameter int CW    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CW-1:0]        out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic             load;
    logic [NCH-1:0]   grant;
    logic [CW-1:0]    grant_idx;
    logic             any;
    logic [WIDTH-1:0] sel_data;

    // Slot can take a word when empty or draining this cycle.
    assign load     = !out_valid || out_ready;
    assign in_ready = load ? grant : '0;

    rr_arbiter #(
        .NCH  (NCH),
        .MODE (MODE)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (load),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_chan  <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
